// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RISC lab core.
// Sequences IF/ID/EX/MEM/WB for the instruction held in the IR, drives the ALU
// operation and datapath enables, and counts retired instructions.
module multicycle_control #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       alu_op,
    output logic             alu_src,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             mem_read,
    output logic             mem_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_LT  = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_XOR = 4'b1101;

    // Wait counter must be able to hold MEM_TIMEOUT itself.
    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        st_if  = 3'd0,
        st_id  = 3'd1,
        st_ex  = 3'd2,
        st_mem = 3'd3,
        st_wb  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   count_q;
    logic               retire;
    logic               timeout;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       is_r, is_i, is_lw, is_sw, is_beq, legal, alt;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign f7b5   = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign is_r   = (opcode == 7'b0110011);
    assign is_i   = (opcode == 7'b0010011);
    assign is_lw  = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_sw  = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign is_beq = (opcode == 7'b1100011) && (funct3 == 3'b000);
    assign legal  = ((is_r || is_i) && (funct3 != 3'b011)) || is_lw || is_sw || is_beq;

    // Immediate forms only use instr[30] as the SRAI selector; elsewhere it is immediate data.
    assign alt = f7b5 && (is_r || (funct3 == 3'b101));

    assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    assign instr_count = rst ? count_q : '0;

    function automatic logic [3:0] decode_alu_op(input logic [2:0] f3, input logic a);
        logic [3:0] op;
        case (f3)
            3'b000:  op = a ? OP_SUB : OP_ADD;
            3'b111:  op = OP_AND;
            3'b110:  op = OP_OR;
            3'b100:  op = OP_XOR;
            3'b010:  op = OP_LT;
            3'b001:  op = OP_SLL;
            3'b101:  op = a ? OP_SRA : OP_SRL;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= st_if;
        else      state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            st_if:   state_next = st_id;
            st_id:   state_next = legal ? st_ex : st_if;
            st_ex: begin
                if (is_beq)              state_next = st_if;
                else if (is_lw || is_sw) state_next = st_mem;
                else                     state_next = st_wb;
            end
            st_mem: begin
                if (timeout)        state_next = st_if;
                else if (mem_ready) state_next = is_lw ? st_wb : st_if;
                else                state_next = st_mem;
            end
            st_wb:   state_next = st_if;
            default: state_next = st_if;
        endcase
    end

    // Control outputs per state; everything held at 0 while in reset.
    always_comb begin
        alu_op     = OP_ADD;
        alu_src    = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        retire     = 1'b0;
        if (!rst) begin
            alu_op = 4'b0000;
        end else begin
            case (state)
                st_if: ir_write = 1'b1;
                st_id: begin
                    if (!legal) begin
                        illegal  = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                st_ex: begin
                    if (is_beq) begin
                        alu_op   = OP_SUB;
                        pc_write = 1'b1;
                        pc_src   = zero;
                        retire   = 1'b1;
                    end else if (is_lw || is_sw) begin
                        alu_src = 1'b1;
                    end else begin
                        alu_op  = decode_alu_op(funct3, alt);
                        alu_src = is_i;
                    end
                end
                st_mem: begin
                    if (timeout) begin
                        mem_err  = 1'b1;
                        pc_write = 1'b1;
                    end else begin
                        mem_read  = is_lw;
                        mem_write = is_sw;
                        if (mem_ready && is_sw) begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                        end
                    end
                end
                st_wb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_lw;
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Memory wait counter: runs only while stalled in MEM, cleared otherwise.
    always_ff @(posedge clk) begin
        if (!rst)
            wait_cnt <= '0;
        else if (state == st_mem && !mem_ready && !timeout && MEM_TIMEOUT != 0)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    // Retired-instruction counter, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst)        count_q <= '0;
        else if (retire) count_q <= count_q + 1'b1;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and compares the control word every cycle.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  alu_op;
    logic        alu_src, ir_write, reg_write, mem_to_reg, mem_read, mem_write;
    logic        pc_write, pc_src, illegal, mem_err;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;

    multicycle_control #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src(alu_src), .ir_write(ir_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
        .pc_write(pc_write), .pc_src(pc_src), .illegal(illegal), .mem_err(mem_err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    logic [13:0] ctl;
    assign ctl = {alu_op, alu_src, ir_write, reg_write, mem_to_reg, mem_read,
                  mem_write, pc_write, pc_src, illegal, mem_err};

    // Control word: op, alu_src, ir_write, reg_write, mem_to_reg, mem_read,
    // mem_write, pc_write, pc_src, illegal, mem_err.
    function automatic logic [13:0] cv(input logic [3:0] op, input logic src, input logic irw,
                                       input logic rw, input logic m2r, input logic mr,
                                       input logic mw, input logic pcw, input logic pcs,
                                       input logic ill, input logic me);
        return {op, src, irw, rw, m2r, mr, mw, pcw, pcs, ill, me};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fetch + decode of a legal instruction; returns in EX.
    task automatic fetch_decode(input string tag, input logic [31:0] ins);
        instr = ins;
        #1;
        check({tag, " IF"}, ctl, cv(ADD,0,1,0,0,0,0,0,0,0,0));
        step();
        check({tag, " ID"}, ctl, cv(ADD,0,0,0,0,0,0,0,0,0,0));
        step();
    endtask

    task automatic run_alu(input string tag, input logic [31:0] ins,
                           input logic [3:0] op, input logic src);
        fetch_decode(tag, ins);
        check({tag, " EX"}, ctl, cv(op,src,0,0,0,0,0,0,0,0,0));
        step();
        check({tag, " WB"}, ctl, cv(ADD,0,0,1,0,0,0,1,0,0,0));
        check({tag, " cnt before"}, instr_count, exp_count);
        step();
        exp_count++;
        check({tag, " cnt after"}, instr_count, exp_count);
    endtask

    task automatic run_lw(input int waits);
        fetch_decode("lw", 32'h0000A183);
        check("lw EX", ctl, cv(ADD,1,0,0,0,0,0,0,0,0,0));
        step();
        for (int i = 0; i < waits; i++) begin
            check("lw MEM wait", ctl, cv(ADD,0,0,0,0,1,0,0,0,0,0));
            step();
        end
        mem_ready = 1'b1;
        #1;
        check("lw MEM ready", ctl, cv(ADD,0,0,0,0,1,0,0,0,0,0));
        step();
        mem_ready = 1'b0;
        #1;
        check("lw WB", ctl, cv(ADD,0,0,1,1,0,0,1,0,0,0));
        step();
        exp_count++;
        check("lw cnt", instr_count, exp_count);
    endtask

    task automatic run_beq(input logic z);
        zero = z;
        fetch_decode("beq", 32'h00208063);
        check("beq EX", ctl, cv(SUB,0,0,0,0,0,0,1,z,0,0));
        step();
        exp_count++;
        check("beq back IF", ctl, cv(ADD,0,1,0,0,0,0,0,0,0,0));
        check("beq cnt", instr_count, exp_count);
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] ins);
        instr = ins;
        #1;
        step();
        check({tag, " ID"}, ctl, cv(ADD,0,0,0,0,0,0,1,0,1,0));
        step();
        check({tag, " back IF"}, ctl, cv(ADD,0,1,0,0,0,0,0,0,0,0));
        check({tag, " cnt"}, instr_count, exp_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; instr = 32'h0; zero = 1'b0; mem_ready = 1'b0;
        step();
        step();
        check("reset ctl", ctl, 14'h0);
        check("reset cnt", instr_count, 0);
        rst = 1'b1;

        run_alu("add",   32'h002081B3, 4'b0010, 1'b0);
        run_alu("sub",   32'h402081B3, 4'b0110, 1'b0);
        run_alu("sra",   32'h4020D1B3, 4'b1010, 1'b0);
        run_alu("slti",  32'h00502193, 4'b0111, 1'b1);
        run_alu("srai",  32'h4030D193, 4'b1010, 1'b1);
        run_alu("addi1024", 32'h40008193, 4'b0010, 1'b1);

        run_lw(3);

        // SW with memory ready from the start; mem_ready outside MEM is ignored.
        mem_ready = 1'b1;
        fetch_decode("sw", 32'h0020A023);
        check("sw EX", ctl, cv(ADD,1,0,0,0,0,0,0,0,0,0));
        step();
        check("sw MEM", ctl, cv(ADD,0,0,0,0,0,1,1,0,0,0));
        step();
        mem_ready = 1'b0;
        exp_count++;
        check("sw cnt", instr_count, exp_count);

        run_beq(1'b1);
        run_beq(1'b0);

        run_illegal("op7f", 32'h0000007F);
        run_illegal("rf3_011", 32'h0020B1B3);

        // Memory never answers: four wait cycles, then the timeout pulse.
        fetch_decode("lwto", 32'h0000A183);
        step();
        for (int i = 0; i < 4; i++) begin
            check("lwto MEM wait", ctl, cv(ADD,0,0,0,0,1,0,0,0,0,0));
            step();
        end
        check("lwto mem_err", ctl, cv(ADD,0,0,0,0,0,0,1,0,0,1));
        step();
        check("lwto back IF", ctl, cv(ADD,0,1,0,0,0,0,0,0,0,0));
        check("lwto cnt", instr_count, exp_count);

        // Reset in the middle of a memory access.
        fetch_decode("lwrst", 32'h0000A183);
        step();
        check("lwrst MEM", ctl, cv(ADD,0,0,0,0,1,0,0,0,0,0));
        step();
        rst = 1'b0;
        #1;
        check("lwrst ctl in rst", ctl, 14'h0);
        check("lwrst cnt in rst", instr_count, 0);
        step();
        check("lwrst ctl held", ctl, 14'h0);
        rst = 1'b1;
        #1;
        check("lwrst IF", ctl, cv(ADD,0,1,0,0,0,0,0,0,0,0));
        check("lwrst cnt cleared", instr_count, 0);
        exp_count = 0;
        run_alu("add2", 32'h002081B3, 4'b0010, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
